mp3_bus_sched: RTL and testbench

Serial-bus scheduler for the VS1003 decoder interface. It shares one SCLK/SI pair between two word-level requesters: the SCI command path (mode and volume writes) and the SDI audio stream (32-bit words from the song ROMs). It owns the hardware-reset sequence, gates each word start on DREQ, and drives XRSET/XCS/XDCS. It sits between the playback/volume logic and the decoder pins.

---
 rtl/mp3_pkg.sv | 20 ++
 rtl/mp3_bus_sched_if.sv | 19 +
 rtl/mp3_tick_gen.sv | 25 ++
 rtl/mp3_bus_sched.sv | 137 +++++++++++++
 tb/tb_mp3_bus_sched.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mp3_pkg.sv
// Shared types and SCI constants for the VS1003 serial-bus scheduler.
package mp3_pkg;

  typedef enum logic [1:0] {
    RST_HOLD,
    IDLE,
    SHIFT,
    GAP
  } state_t;

  localparam logic [7:0]  SCI_WRITE = 8'h02;
  localparam logic [7:0]  SCI_MODE  = 8'h00;
  localparam logic [7:0]  SCI_VOL   = 8'h0B;

  localparam logic [31:0] MODE_INIT = {SCI_WRITE, SCI_MODE, 16'h0800};
  localparam logic [31:0] VOL_INIT  = {SCI_WRITE, SCI_VOL,  16'h6666};

  localparam logic [5:0]  WORD_RISES = 6'd32;

endpackage

// File: rtl/mp3_bus_sched_if.sv
// Word-level request handshakes for the SCI command path and the SDI audio stream.
interface mp3_bus_sched_if;
  logic        cmd_valid;
  logic [31:0] cmd_data;
  logic        cmd_ready;
  logic        dat_valid;
  logic [31:0] dat_data;
  logic        dat_ready;

  modport master (
    output cmd_valid, cmd_data, dat_valid, dat_data,
    input  cmd_ready, dat_ready
  );

  modport slave (
    input  cmd_valid, cmd_data, dat_valid, dat_data,
    output cmd_ready, dat_ready
  );
endinterface

// File: rtl/mp3_tick_gen.sv
// Bus-tick divider: one-cycle enable every CLK_DIV clocks, restartable via clear.
module mp3_tick_gen #(
  parameter int unsigned CLK_DIV = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  localparam int unsigned W = $clog2(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    if (clear) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mp3_bus_sched.sv
// Shares one SCLK/SI pair between the SCI command and SDI audio requesters,
// owns the decoder hardware-reset sequence and gates word starts on DREQ.
module mp3_bus_sched
  import mp3_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 50,
  parameter int unsigned RESET_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  DREQ,
  input  logic                  hw_reset_req,
  mp3_bus_sched_if.slave        bus,
  output logic                  busy,
  output logic                  XRSET,
  output logic                  XCS,
  output logic                  XDCS,
  output logic                  SI,
  output logic                  SCLK
);
  localparam int unsigned RC_W = $clog2(RESET_CYCLES + 1);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RESET_CYCLES - 1);

  state_t           state_q, state_d;
  logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [5:0]       bit_cnt_q, bit_cnt_d;
  logic [31:0]      shreg_q, shreg_d;
  logic             sclk_q, sclk_d;
  logic             xrset_q, xrset_d;
  logic             xcs_q, xcs_d;
  logic             xdcs_q, xdcs_d;
  logic             tick, cmd_acc, dat_acc;

  mp3_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (hw_reset_req),
    .tick  (tick)
  );

  assign cmd_acc       = (state_q == IDLE) && tick && DREQ && bus.cmd_valid;
  assign dat_acc       = (state_q == IDLE) && tick && DREQ && !bus.cmd_valid && bus.dat_valid;
  assign bus.cmd_ready = cmd_acc;
  assign bus.dat_ready = dat_acc;

  assign busy  = (state_q != IDLE);
  assign XRSET = xrset_q;
  assign XCS   = xcs_q;
  assign XDCS  = xdcs_q;
  assign SCLK  = sclk_q;
  assign SI    = shreg_q[31];

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    sclk_d    = sclk_q;
    xrset_d   = xrset_q;
    xcs_d     = xcs_q;
    xdcs_d    = xdcs_q;

    if (hw_reset_req) begin
      state_d   = RST_HOLD;
      rst_cnt_d = '0;
      bit_cnt_d = '0;
      shreg_d   = '0;
      sclk_d    = 1'b0;
      xrset_d   = 1'b0;
      xcs_d     = 1'b1;
      xdcs_d    = 1'b1;
    end else if (tick) begin
      unique case (state_q)
        RST_HOLD: begin
          if (rst_cnt_q == RC_LAST) begin
            rst_cnt_d = '0;
            xrset_d   = 1'b1;
            state_d   = IDLE;
          end else begin
            rst_cnt_d = rst_cnt_q + 1'b1;
          end
        end
        IDLE: begin
          if (cmd_acc || dat_acc) begin
            shreg_d   = cmd_acc ? bus.cmd_data : bus.dat_data;
            xcs_d     = !cmd_acc;
            xdcs_d    = !dat_acc;
            sclk_d    = 1'b0;
            bit_cnt_d = '0;
            state_d   = SHIFT;
          end
        end
        SHIFT: begin
          // Rising ticks count edges; falling ticks shift, except the one
          // after the 32nd rise, which releases the chip selects instead.
          if (!sclk_q) begin
            sclk_d    = 1'b1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_cnt_q == WORD_RISES) begin
              xcs_d   = 1'b1;
              xdcs_d  = 1'b1;
              state_d = GAP;
            end else begin
              shreg_d = {shreg_q[30:0], 1'b0};
            end
          end
        end
        GAP:     state_d = IDLE;
        default: state_d = RST_HOLD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RST_HOLD;
      rst_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      sclk_q    <= 1'b0;
      xrset_q   <= 1'b0;
      xcs_q     <= 1'b1;
      xdcs_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      sclk_q    <= sclk_d;
      xrset_q   <= xrset_d;
      xcs_q     <= xcs_d;
      xdcs_q    <= xdcs_d;
    end
  end
endmodule

// File: tb/tb_mp3_bus_sched.sv
// Bench for mp3_bus_sched: tick-timeline reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mp3_bus_sched;
  localparam int unsigned CLK_DIV      = 2;
  localparam int unsigned RESET_CYCLES = 4;

  logic clk = 1'b0;
  logic rst, DREQ, hw_reset_req;
  logic busy, XRSET, XCS, XDCS, SI, SCLK;

  mp3_bus_sched_if bus ();

  mp3_bus_sched #(.CLK_DIV(CLK_DIV), .RESET_CYCLES(RESET_CYCLES)) dut (
    .clk          (clk),
    .rst          (rst),
    .DREQ         (DREQ),
    .hw_reset_req (hw_reset_req),
    .bus          (bus),
    .busy         (busy),
    .XRSET        (XRSET),
    .XCS          (XCS),
    .XDCS         (XDCS),
    .SI           (SI),
    .SCLK         (SCLK)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;
  bit chk_en = 1'b0;

  // Model: mode 0 = decoder held in reset, 1 = idle, 2 = word in flight
  // (m_t = ticks since accept; 64 is the inter-word gap tick).
  int          m_mode = 0;
  int          m_t    = 0;
  int          m_cyc  = 0;
  logic [31:0] m_word = '0;
  logic        m_is_cmd = 1'b0;
  logic        m_si_rest = 1'b0;

  // Observations of the DUT pins for the directed checks.
  logic        prev_sclk = 1'b0, prev_xcs = 1'b1, prev_xdcs = 1'b1;
  logic [31:0] rx = '0, last_rx = '0;
  int          rises = 0, last_rises = 0;
  int          n_cmd = 0, n_dat = 0, cmd_acc_cyc = 0, dat_acc_cyc = 0;
  int          xcs_low = 0, xdcs_low = 0;
  logic        acc_c, acc_d;

  function automatic logic m_tick();
    return ((m_cyc + 1) % CLK_DIV) == 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc_n, act, exp);
    end
  endtask

  task automatic cycle();
    logic e_xrset, e_xcs, e_xdcs, e_sclk, e_si, e_busy, e_cr, e_dr, tk;
    #1;
    acc_c = 1'b0;
    acc_d = 1'b0;
    if (chk_en) begin
      e_xrset = (m_mode != 0);
      e_busy  = (m_mode != 1);
      e_xcs   = 1'b1;
      e_xdcs  = 1'b1;
      e_sclk  = 1'b0;
      e_si    = m_si_rest;
      if (m_mode == 2 && m_t < 64) begin
        e_xcs  = !m_is_cmd;
        e_xdcs = m_is_cmd;
        e_sclk = (m_t % 2) == 1;
        e_si   = m_word[31 - m_t / 2];
      end
      e_cr = (m_mode == 1) && m_tick() && DREQ && bus.cmd_valid;
      e_dr = (m_mode == 1) && m_tick() && DREQ && !bus.cmd_valid && bus.dat_valid;
      chk("XRSET", XRSET, e_xrset);
      chk("XCS", XCS, e_xcs);
      chk("XDCS", XDCS, e_xdcs);
      chk("SCLK", SCLK, e_sclk);
      chk("SI", SI, e_si);
      chk("busy", busy, e_busy);
      chk("cmd_ready", bus.cmd_ready, e_cr);
      chk("dat_ready", bus.dat_ready, e_dr);

      acc_c = bus.cmd_ready;
      acc_d = bus.dat_ready;
      if (acc_c || acc_d) begin
        rises = 0; rx = '0; xcs_low = 0; xdcs_low = 0;
      end
      if (acc_c) begin n_cmd++; cmd_acc_cyc = cyc_n; end
      if (acc_d) begin n_dat++; dat_acc_cyc = cyc_n; end
      if (SCLK && !prev_sclk) begin rises++; rx = {rx[30:0], SI}; end
      if ((XCS && !prev_xcs) || (XDCS && !prev_xdcs)) begin
        last_rx = rx; last_rises = rises;
      end
      if (!XCS)  xcs_low++;
      if (!XDCS) xdcs_low++;
      prev_sclk = SCLK; prev_xcs = XCS; prev_xdcs = XDCS;
    end

    @(posedge clk);
    if (rst || hw_reset_req) begin
      m_mode = 0; m_t = 0; m_cyc = 0; m_si_rest = 1'b0;
    end else begin
      tk = m_tick();
      m_cyc++;
      if (tk) begin
        case (m_mode)
          0: begin
            m_t++;
            if (m_t == RESET_CYCLES) m_mode = 1;
          end
          1: if (DREQ && (bus.cmd_valid || bus.dat_valid)) begin
            m_mode   = 2;
            m_t      = 0;
            m_is_cmd = bus.cmd_valid;
            m_word   = bus.cmd_valid ? bus.cmd_data : bus.dat_data;
          end
          default: begin
            m_t++;
            if (m_t == 64) m_si_rest = m_word[0];
            if (m_t == 65) m_mode = 1;
          end
        endcase
      end
    end
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic count_xrset_low(output int lows);
    int guard;
    lows = 0;
    guard = 0;
    while (XRSET !== 1'b1 && guard < 40) begin
      lows++; guard++;
      cycle();
    end
  endtask

  task automatic wait_accept(input bit is_cmd, output bit got);
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      cycle();
      if (is_cmd ? acc_c : acc_d) got = 1'b1;
    end
  endtask

  initial begin
    int lows, d, drop_cyc, idx;
    bit got, dropped, w2_checked;
    logic [31:0] w [3];

    rst = 1'b1; hw_reset_req = 1'b0; DREQ = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_data = '0;
    bus.dat_valid = 1'b0; bus.dat_data = '0;
    @(negedge clk);
    cycle();
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state and reset-hold duration: 4 ticks = 8 clocks.
    chk("rst_XRSET", XRSET, 1'b0);
    chk("rst_XCS", XCS, 1'b1);
    chk("rst_XDCS", XDCS, 1'b1);
    chk("rst_SCLK", SCLK, 1'b0);
    chk("rst_busy", busy, 1'b1);
    count_xrset_low(lows);
    chk("rst_hold_cycles", lows, 8);

    // Single SCI word.
    DREQ = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_data = 32'h020B6666;
    wait_accept(1'b1, got);
    chk("cmd_accepted", got, 1'b1);
    bus.cmd_valid = 1'b0;
    repeat (140) cycle();
    chk("cmd_readback", last_rx, 32'h020B6666);
    chk("cmd_rises", last_rises, 32);
    chk("cmd_ready_pulses", n_cmd, 1);
    chk("xcs_low_cycles", xcs_low, 128);

    // Simultaneous requests: cmd first, dat 66 ticks later.
    bus.cmd_valid = 1'b1; bus.cmd_data = 32'h02000800;
    bus.dat_valid = 1'b1; bus.dat_data = $urandom;
    for (int i = 0; i < 400 && (bus.cmd_valid || bus.dat_valid); i++) begin
      cycle();
      if (acc_c) bus.cmd_valid = 1'b0;
      if (acc_d) bus.dat_valid = 1'b0;
    end
    chk("tie_both_accepted", {bus.cmd_valid, bus.dat_valid}, 2'b00);
    chk("tie_dat_after_cmd", dat_acc_cyc - cmd_acc_cyc, 66 * CLK_DIV);
    repeat (140) cycle();

    // DREQ low holds off an SDI word.
    DREQ = 1'b0;
    d = n_dat;
    bus.dat_valid = 1'b1; bus.dat_data = 32'hA5A5_0F0F;
    repeat (10 * CLK_DIV) cycle();
    chk("dreq0_no_accept", n_dat - d, 0);
    DREQ = 1'b1;
    drop_cyc = cyc_n;
    wait_accept(1'b0, got);
    bus.dat_valid = 1'b0;
    chk("dreq_accepted", got, 1'b1);
    chk("dreq_latency_ok", (dat_acc_cyc - drop_cyc) < CLK_DIV, 1'b1);
    repeat (140) cycle();
    chk("dat_readback", last_rx, 32'hA5A5_0F0F);
    chk("xdcs_low_cycles", xdcs_low, 128);

    // Hardware reset at bit 16 of an SDI word.
    bus.dat_valid = 1'b1; bus.dat_data = $urandom;
    wait_accept(1'b0, got);
    bus.dat_valid = 1'b0;
    for (int i = 0; i < 200 && rises < 16; i++) cycle();
    chk("hw_reached_bit16", rises, 16);
    d = n_dat;
    hw_reset_req = 1'b1;
    cycle();
    hw_reset_req = 1'b0;
    chk("hw_XRSET", XRSET, 1'b0);
    chk("hw_XDCS", XDCS, 1'b1);
    chk("hw_SCLK", SCLK, 1'b0);
    count_xrset_low(lows);
    chk("hw_hold_cycles", lows, 8);
    repeat (140) cycle();
    chk("hw_word_aborted_bits", last_rises, 16);
    chk("hw_no_new_accept", n_dat - d, 0);

    // Three-word stream with DREQ dropped during the second word.
    for (int i = 0; i < 3; i++) w[i] = $urandom;
    idx = 0; dropped = 1'b0; w2_checked = 1'b0; drop_cyc = 0;
    bus.dat_valid = 1'b1; bus.dat_data = w[0];
    for (int i = 0; i < 1500 && idx < 3; i++) begin
      cycle();
      if (acc_d) begin
        idx++;
        if (idx < 3) bus.dat_data = w[idx];
        else         bus.dat_valid = 1'b0;
      end
      if (idx == 2 && !dropped && rises == 10) begin
        DREQ = 1'b0; dropped = 1'b1; drop_cyc = cyc_n;
      end
      if (dropped && !w2_checked && cyc_n - drop_cyc == 150) begin
        chk("stream_w2_bits", last_rises, 32);
        chk("stream_w2_data", last_rx, w[1]);
        chk("stream_w3_waits", idx, 2);
        w2_checked = 1'b1;
        DREQ = 1'b1;
      end
    end
    chk("stream_done", idx, 3);
    repeat (140) cycle();
    chk("stream_w3_data", last_rx, w[2]);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      DREQ = ($urandom_range(0, 9) != 0);
      if (!bus.cmd_valid && $urandom_range(0, 15) == 0) begin
        bus.cmd_valid = 1'b1; bus.cmd_data = $urandom;
      end
      if (!bus.dat_valid && $urandom_range(0, 3) == 0) begin
        bus.dat_valid = 1'b1; bus.dat_data = $urandom;
      end
      hw_reset_req = ($urandom_range(0, 599) == 0);
      rst = ($urandom_range(0, 1999) == 0);
      cycle();
      hw_reset_req = 1'b0;
      rst = 1'b0;
      if (acc_c) bus.cmd_valid = 1'b0;
      if (acc_d) bus.dat_valid = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
